// File: rtl/uart8_pkg.sv
// uart8_pkg: shared FSM state encoding, frame/oversampling constants and the 2-of-3 vote.
package uart8_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI = 9;
  localparam int DATA_BITS = 8;
  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart8_baud_gen.sv
// uart8_baud_gen: free-running dividers producing 16x rx and 1x tx baud tick strobes.
module uart8_baud_gen import uart8_pkg::*; #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic clk,
  input  logic rst_n,
  output logic rxTick,
  output logic txTick
);
  localparam int RX_DIV = CLOCK_RATE / (OVERSAMPLE * BAUD_RATE);
  localparam int TX_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int RX_W = $clog2(RX_DIV);
  localparam int TX_W = $clog2(TX_DIV);
  logic [RX_W-1:0] rxCnt;
  logic [TX_W-1:0] txCnt;
  assign rxTick = rxCnt == RX_W'(RX_DIV - 1);
  assign txTick = txCnt == TX_W'(TX_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rxCnt <= '0;
      txCnt <= '0;
    end else begin
      rxCnt <= rxTick ? '0 : rxCnt + 1'b1;
      txCnt <= txTick ? '0 : txCnt + 1'b1;
    end
endmodule

// File: rtl/uart8_8n1.sv
// uart8_8n1: full-duplex 8N1 UART, 16x oversampled receiver with mid-bit majority vote.
// Define UART8_TX_EN to include the transmitter; otherwise tx idles high and tx inputs are ignored.
module uart8_8n1 import uart8_pkg::*; #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxEn,
  input  logic       rx,
  output logic       rxBusy,
  output logic       rxDone,
  output logic       rxErr,
  output logic [7:0] out,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       txBusy,
  output logic       txDone,
  output logic       tx
);
  logic rxTick, txTick;
  logic [1:0] rxSync;
  logic rxS;
  stateT rxState, rxNext;
  logic [3:0] rxSample, rxSampleNext;
  logic [2:0] rxBit;
  logic [DATA_BITS-1:0] rxShift;
  logic rxV7, rxV8, rxMaj, rxAt9, rxAt15, rxStartDet, rxStopOk, rxStopBad;

  uart8_baud_gen #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) baudGen (
    .clk(clk), .rst_n(rst_n), .rxTick(rxTick), .txTick(txTick)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rxSync <= 2'b11;
    else rxSync <= {rxSync[0], rx};
  assign rxS = rxSync[1];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rxState <= IDLE;
    else rxState <= rxNext;

  // rxSampleNext is the index of the sample being taken on this tick
  always_comb begin
    rxSampleNext = rxSample + 4'd1;
    rxMaj = majority(rxV7, rxV8, rxS);
    rxAt9 = rxTick && rxSampleNext == 4'(SAMPLE_HI);
    rxAt15 = rxTick && rxSampleNext == 4'(OVERSAMPLE - 1);
    rxNext = rxState;
    case (rxState)
      IDLE:    rxNext = rxTick && !rxS ? START : IDLE;
      START:   rxNext = rxAt9 && rxMaj ? IDLE : rxAt15 ? DATA : START;
      DATA:    rxNext = rxAt15 && rxBit == 3'(DATA_BITS - 1) ? STOP : DATA;
      STOP:    rxNext = rxAt9 ? IDLE : STOP;
      default: rxNext = IDLE;
    endcase
    if (!rxEn) rxNext = IDLE;
  end

  always_comb begin
    rxBusy = rxState != IDLE;
    rxStartDet = rxState == IDLE && rxNext == START;
    rxStopOk = rxState == STOP && rxEn && rxAt9 && rxMaj;
    rxStopBad = rxState == STOP && rxEn && rxAt9 && !rxMaj;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rxSample <= '0;
      rxBit <= '0;
      rxShift <= '0;
      rxV7 <= 1'b1;
      rxV8 <= 1'b1;
      rxDone <= 1'b0;
      rxErr <= 1'b0;
      out <= '0;
    end else begin
      rxDone <= rxStopOk;
      rxSample <= rxStartDet ? 4'd0 : rxTick && rxBusy ? rxSampleNext : rxSample;
      rxBit <= rxStartDet ? 3'd0 : rxState == DATA && rxAt15 ? rxBit + 3'd1 : rxBit;
      if (rxTick && rxSampleNext == 4'(SAMPLE_LO)) rxV7 <= rxS;
      if (rxTick && rxSampleNext == 4'(SAMPLE_MID)) rxV8 <= rxS;
      if (rxState == DATA && rxAt9) rxShift <= {rxMaj, rxShift[DATA_BITS-1:1]};
      if (rxStopOk) out <= rxShift;
      rxErr <= rxStartDet ? 1'b0 : rxStopBad ? 1'b1 : rxErr;
    end

`ifdef UART8_TX_EN
  stateT txState, txNext;
  logic [2:0] txBit;
  logic [DATA_BITS-1:0] txData;
  logic txLine, txLineNext;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) txState <= IDLE;
    else txState <= txNext;

  // In START the line stays high until the first tick; a low line means the start bit is out
  always_comb begin
    txNext = txState;
    case (txState)
      IDLE:    txNext = txStart ? START : IDLE;
      START:   txNext = txTick && !txLine ? DATA : START;
      DATA:    txNext = txTick && txBit == 3'(DATA_BITS - 1) ? STOP : DATA;
      STOP:    txNext = txTick ? IDLE : STOP;
      default: txNext = IDLE;
    endcase
    if (!txEn) txNext = IDLE;
  end

  always_comb begin
    txBusy = txState != IDLE;
    txLineNext = txState == IDLE || txNext == IDLE || txNext == STOP ? 1'b1 :
                 !txTick ? txLine :
                 txNext == START ? 1'b0 :
                 txData[txState == START ? 3'd0 : txBit + 3'd1];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      txBit <= '0;
      txData <= '0;
      txLine <= 1'b1;
      txDone <= 1'b0;
    end else begin
      txData <= txState == IDLE && txNext == START ? in : txData;
      txBit <= txState == START ? 3'd0 : txState == DATA && txTick ? txBit + 3'd1 : txBit;
      txLine <= txLineNext;
      txDone <= txState == STOP && txTick && txEn;
    end
  assign tx = txLine;
`else
  logic unusedTx;
  assign unusedTx = ^{txEn, txStart, in, txTick};
  assign txBusy = 1'b0;
  assign txDone = 1'b0;
  assign tx = 1'b1;
`endif
endmodule

// File: tb/tb_uart8_8n1.sv
// tb_uart8_8n1: directed frames with a byte scoreboard on rxDone and a tx line decoder.
// Clock scaled to 1.536 MHz so a bit is exactly 160 clks and a sample tick 10 clks.
`timescale 1ns/1ps
module tb_uart8_8n1;
  localparam int CLOCK_RATE = 1536000;
  localparam int BAUD_RATE = 9600;
  localparam int BIT = 160;
  logic clk = 1'b0, rst_n = 1'b0, rxEn = 1'b1, rxDrv = 1'b1, loop = 1'b0;
  logic txEn = 1'b1, txStart = 1'b0, txMon = 1'b0;
  logic [7:0] in = 8'h00;
  logic rx, rxBusy, rxDone, rxErr, txBusy, txDone, tx;
  logic [7:0] out;
  int compared = 0, mismatched = 0;
  int busyCnt = 0, doneCnt = 0, txDoneCnt = 0, txLowCnt = 0;
  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];

  assign rx = loop ? tx : rxDrv;
  always #5 clk = ~clk;

  uart8_8n1 #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .rxEn(rxEn), .rx(rx), .rxBusy(rxBusy), .rxDone(rxDone),
    .rxErr(rxErr), .out(out), .txEn(txEn), .txStart(txStart), .in(in),
    .txBusy(txBusy), .txDone(txDone), .tx(tx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rxFrame(input logic [7:0] d, input int stopLow, input bit glitch);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxDrv = f[i];
      if (i == 9 && stopLow > 0) begin
        rxDrv = 1'b0;
        clks(stopLow);
        rxDrv = 1'b1;
        clks(BIT - stopLow);
      end else if (i == 9 && glitch) begin
        clks(9);
        rxDrv = 1'b0;
        clks(21);
        rxDrv = 1'b1;
        clks(BIT - 30);
      end else clks(BIT);
    end
  endtask

  // rx scoreboard and event counters
  initial forever begin
    logic [7:0] exp;
    @(negedge clk);
    if (rst_n) begin
      if (rxBusy) busyCnt++;
      if (!tx) txLowCnt++;
      if (txDone) txDoneCnt++;
      if (rxDone) begin
        doneCnt++;
        if (rxQ.size() != 0) exp = rxQ.pop_front();
        else exp = 'x;
        check("rx byte", 32'(out), 32'(exp));
      end
    end
  end

  // tx line decoder, sampling each bit at its middle
  initial begin
    logic [7:0] d, exp;
    int w;
    forever begin
      @(negedge clk);
      if (txMon && !tx) begin
        clks(BIT / 2);
        check("tx start bit", 32'(tx), 0);
        for (int i = 0; i < 8; i++) begin
          clks(BIT);
          d[i] = tx;
        end
        clks(BIT);
        check("tx stop bit", 32'(tx), 1);
        if (txQ.size() != 0) exp = txQ.pop_front();
        else exp = 'x;
        check("tx byte", 32'(d), 32'(exp));
        w = 0;
        while (!txDone && w < BIT) begin
          clks(1);
          w++;
        end
        check("tx txDone pulse", 32'(txDone), 1);
      end
    end
  end

  initial begin
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int b0, d0, t0, l0, w;
    clks(3);
    check("reset rxBusy", 32'(rxBusy), 0);
    check("reset rxDone", 32'(rxDone), 0);
    check("reset rxErr", 32'(rxErr), 0);
    check("reset out", 32'(out), 0);
    check("reset txBusy", 32'(txBusy), 0);
    check("reset txDone", 32'(txDone), 0);
    check("reset tx", 32'(tx), 1);
    rst_n = 1'b1;
    clks(20);
    b0 = busyCnt; d0 = doneCnt;
    rxQ.push_back(8'hB5);
    rxFrame(8'hB5, 0, 0);
    clks(40);
    check("good busy clks", busyCnt - b0, 1530);
    check("good rxDone count", doneCnt - d0, 1);
    check("good rxErr", 32'(rxErr), 0);
    d0 = doneCnt;
    rxQ.push_back(8'hB5);
    rxFrame(8'hB5, 0, 1);
    clks(40);
    check("glitch rxDone count", doneCnt - d0, 1);
    check("glitch rxErr", 32'(rxErr), 0);
    check("glitch out", 32'(out), 32'hB5);
    d0 = doneCnt;
    rxFrame(8'h5A, 95, 0);
    clks(40);
    check("bad stop rxErr", 32'(rxErr), 1);
    check("bad stop rxDone count", doneCnt - d0, 0);
    check("bad stop out kept", 32'(out), 32'hB5);
    check("bad stop rxBusy", 32'(rxBusy), 0);
    b0 = busyCnt; d0 = doneCnt;
    rxDrv = 1'b0;
    clks(46);
    rxDrv = 1'b1;
    clks(150);
    check("false start busy clks", busyCnt - b0, 90);
    check("false start rxDone count", doneCnt - d0, 0);
    check("start clears rxErr", 32'(rxErr), 0);
    d0 = doneCnt;
    fork
      rxFrame(8'hB5, 0, 0);
      begin
        clks(800);
        check("mid rxBusy", 32'(rxBusy), 1);
        rxEn = 1'b0;
        clks(1);
        check("rxEn drop idle", 32'(rxBusy), 0);
      end
    join
    clks(40);
    check("rxEn drop rxDone count", doneCnt - d0, 0);
    b0 = busyCnt; d0 = doneCnt;
    rxFrame(8'hB5, 0, 0);
    clks(40);
    check("rxEn off busy clks", busyCnt - b0, 0);
    check("rxEn off rxDone count", doneCnt - d0, 0);
    rxEn = 1'b1;
    clks(20);
`ifdef UART8_TX_EN
    loop = 1'b1; txMon = 1'b1;
    d0 = doneCnt; t0 = txDoneCnt;
    rxQ.push_back(8'h3C);
    txQ.push_back(8'h3C);
    in = 8'h3C; txStart = 1'b1;
    clks(1);
    txStart = 1'b0;
    check("txBusy set", 32'(txBusy), 1);
    clks(300);
    in = 8'hFF; txStart = 1'b1;
    clks(1);
    txStart = 1'b0;
    w = 0;
    while (txBusy && w < 4000) begin
      clks(1);
      w++;
    end
    check("tx frame ends", 32'(txBusy), 0);
    clks(200);
    check("loopback rxDone count", doneCnt - d0, 1);
    check("tx txDone count", txDoneCnt - t0, 1);
    txMon = 1'b0; loop = 1'b0;
    t0 = txDoneCnt;
    in = 8'h00; txStart = 1'b1;
    clks(1);
    txStart = 1'b0;
    clks(500);
    check("tx mid frame low", 32'(tx), 0);
    txEn = 1'b0;
    clks(1);
    check("txEn drop tx", 32'(tx), 1);
    check("txEn drop txBusy", 32'(txBusy), 0);
    txEn = 1'b1;
    clks(1700);
    check("txEn drop txDone count", txDoneCnt - t0, 0);
`else
    t0 = txDoneCnt; l0 = txLowCnt;
    in = 8'h3C; txStart = 1'b1;
    clks(1);
    txStart = 1'b0;
    check("tx disabled txBusy", 32'(txBusy), 0);
    clks(1700);
    check("tx disabled line low clks", txLowCnt - l0, 0);
    check("tx disabled txDone count", txDoneCnt - t0, 0);
`endif
    in = 8'h00; txStart = 1'b1;
    clks(1);
    txStart = 1'b0;
    fork
      rxFrame(8'hFC, 0, 0);
      begin
        clks(500);
        check("pre-reset rxBusy", 32'(rxBusy), 1);
`ifdef UART8_TX_EN
        check("pre-reset tx low", 32'(tx), 0);
`endif
        rst_n = 1'b0;
        #1;
        check("async reset tx", 32'(tx), 1);
        check("async reset txBusy", 32'(txBusy), 0);
        check("async reset txDone", 32'(txDone), 0);
        check("async reset rxBusy", 32'(rxBusy), 0);
        check("async reset rxDone", 32'(rxDone), 0);
        check("async reset rxErr", 32'(rxErr), 0);
        check("async reset out", 32'(out), 0);
        clks(2);
        rst_n = 1'b1;
      end
    join
    clks(100);
    check("rx queue drained", rxQ.size(), 0);
    check("tx queue drained", txQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart8_8n1.md
Name: uart8_8n1

Overview:
- Full-duplex 8N1 UART: 8 data bits, no parity, 1 stop bit, LSB first.
- Serial side connects to the board pins. Byte side connects to the fabric through busy/done/error strobes.
- Receiver oversamples at 16x baud and majority-votes each bit at mid-bit. Transmitter shifts out at baud rate.

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: serial bit rate in baud.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rxEn  in  1  receiver enable.
- rx  in  1  serial input; idle high; asynchronous to clk.
- rxBusy  out  1  receive frame in progress.
- rxDone  out  1  one-clk pulse: valid byte on out.
- rxErr  out  1  framing error flag.
- out  out  8  last good received byte.
- txEn  in  1  transmitter enable.
- txStart  in  1  request to send in.
- in  in  8  byte to transmit.
- txBusy  out  1  transmit in progress.
- txDone  out  1  one-clk pulse at end of stop bit.
- tx  out  1  serial output; idle high.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset values: rxBusy=0, rxDone=0, rxErr=0, out=8'h00, txBusy=0, txDone=0, tx=1.
  - All counters and state machines return to IDLE on reset, including mid-frame.
- Tick generation:
  - Rx tick every RX_DIV = CLOCK_RATE/(16*BAUD_RATE) clks, integer truncated; 78 at defaults.
  - Tx tick every TX_DIV = CLOCK_RATE/BAUD_RATE clks; 1250 at defaults.
  - Both dividers are free-running counters that wrap to 0.
- rx input: 2-flop synchronizer before any use.
- Receiver states IDLE -> START -> DATA -> STOP -> IDLE. A 4-bit sample counter increments on each rx tick.
- IDLE:
  - If rxEn=1 and the synchronized rx is low on an rx tick: go to START, sample counter=0, rxBusy=1.
  - Clear rxErr on this transition.
- START:
  - Take the majority of samples 7, 8 and 9.
  - If the majority is high, it is a false start: return to IDLE, rxBusy=0, no strobe.
  - Otherwise, after sample 15, go to DATA with bit index 0.
- DATA:
  - Each bit = majority of samples 7, 8 and 9, shifted in LSB first.
  - After sample 15 of bit 7, go to STOP.
- STOP:
  - Decision at sample 9, using the majority of samples 7, 8 and 9.
  - Samples 0-6 are ignored, so glitches there have no effect.
  - Majority high: out <= shift register, rxDone pulses for 1 clk.
  - Majority low: rxErr <= 1 and stays set until the next start detection; out unchanged; no rxDone.
  - In both cases: rxBusy=0, then IDLE. The next start edge is accepted from the following rx tick.
- rxEn=0 mid-frame: immediate return to IDLE, rxBusy=0, no rxDone, rxErr unchanged.
- Transmitter states IDLE -> START -> DATA -> STOP -> IDLE.
  - Trigger: txStart=1 with txEn=1 in IDLE latches in and sets txBusy=1 on the next clk.
  - The start bit begins at the next tx tick.
  - tx is driven low for 1 bit time, then in[0..7], then high for 1 bit time.
  - At the end of the stop bit: txDone pulses 1 clk, txBusy=0.
  - txStart while busy is ignored.
  - txEn=0 mid-frame: tx=1, txBusy=0 immediately, no txDone.
- Receiver and transmitter are fully independent. Loopback of tx to rx must work.

Optional Feature:
- Macro: UART8_TX_EN.
- Defined: transmitter included as specified.
- Undefined: transmitter logic removed; tx tied 1, txBusy tied 0, txDone tied 0; txEn, txStart and in are ignored. Ports remain present.

Decomposition:
- Package uart8_pkg holds:
  - enum for states IDLE/START/DATA/STOP (shared by rx and tx);
  - localparams OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, DATA_BITS=8.
- Sub-module uart8_baud_gen generates rx and tx tick strobes from CLOCK_RATE and BAUD_RATE. Instantiated once.
- Rx and tx FSMs stay in the top.

Test Plan:
- Receive 8'hB5 at 9600 baud, 12 MHz: frame 0,1,0,1,0,1,1,0,1,1 with 1042 us/10 bit spacing -> out=8'hB5, one rxDone pulse, rxErr=0, rxBusy high for about 9.5 bit times.
- Same frame, with a 14 us low glitch on rx about 6-20 us into the stop bit -> still out=8'hB5, rxDone pulse, rxErr=0.
- Same frame, stop bit held low through mid-bit -> rxErr=1, no rxDone, out keeps its previous value. rxErr clears at the next start detection.
- rx low for 30 us, then high, with rxEn=1 -> rxBusy pulses then drops at the mid-start check; no rxDone, no rxErr.
- rxEn=0 during a full 8'hB5 frame -> rxBusy stays 0, no strobes. Deasserting rxEn mid-frame -> immediate idle.
- With UART8_TX_EN defined, txStart with in=8'h3C -> tx waveform low,0,0,1,1,1,1,0,0,high at 104.17 us/bit, then a txDone pulse. Looped to rx, this gives out=8'h3C. Asserting rst_n low mid-frame -> tx=1, all flags 0 immediately.
